alu_mc: RTL and testbench



---
 rtl/alu_mc_pkg.sv | 29 ++
 rtl/alu_mc_if.sv | 28 ++
 rtl/alu_mc_iter.sv | 87 ++++++++
 rtl/alu_mc.sv | 116 +++++++++++
 tb/tb_alu_mc.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM encoding and
// the multi-cycle opcode classifier. Optional divide: ALU_MC_DIV_EN.
package alu_mc_pkg;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_SLT = 2;
    localparam int unsigned OP_SLL = 3;
    localparam int unsigned OP_SLR = 4;
    localparam int unsigned OP_AND = 5;
    localparam int unsigned OP_MUL = 6;
    localparam int unsigned OP_DIV = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // True for opcodes that run through the iterative datapath.
    function automatic logic is_multicycle(input logic [31:0] op);
`ifdef ALU_MC_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the controller (master) and alu_mc (slave).
interface alu_mc_if #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, A, b, op, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, ovf, illegal
    );

    modport slave (
        input  in_valid, A, b, op, out_ready,
        output in_ready, out_valid, result, result_hi, zero, ovf, illegal
    );
endinterface

// File: rtl/alu_mc_iter.sv
// Iterative datapath: shift-add multiplier and, with ALU_MC_DIV_EN, a
// restoring divider sharing the same 2*WIDTH accumulator. `acc` is the value
// produced by the current step; it is final on the cycle `done` is high.
module alu_mc_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
`ifdef ALU_MC_DIV_EN
    input  logic               mode,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] acc
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] step;
    logic [WIDTH-1:0]   opnd_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic [WIDTH:0]     mul_sum;
`ifdef ALU_MC_DIV_EN
    logic               mode_q;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
`endif

    // One step: multiplier adds the multiplicand into the high half when the
    // current multiplier bit is set; divider shifts and conditionally subtracts.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        if (acc_q[0]) begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            step = {1'b0, acc_q[2*WIDTH-1:1]};
        end
`ifdef ALU_MC_DIV_EN
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, opnd_q};
        if (mode_q) begin
            if (rem_sh >= {1'b0, opnd_q}) begin
                step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign acc  = step;
    assign done = busy_q && (cnt_q == '0);

    // Load operands on start, then run WIDTH steps counting down to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
`ifdef ALU_MC_DIV_EN
            mode_q <= 1'b0;
`endif
        end else if (start) begin
`ifdef ALU_MC_DIV_EN
            mode_q <= mode;
            acc_q  <= mode ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            opnd_q <= mode ? b : a;
`else
            acc_q  <= {{WIDTH{1'b0}}, b};
            opnd_q <= a;
`endif
            cnt_q  <= CW'(WIDTH - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= step;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle datapath, flags and the
// iterative mul/div unit. Op 7 is divide only when ALU_MC_DIV_EN is defined.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic     clock,
    input  logic     reset,
    alu_mc_if.slave  bus
);
    import alu_mc_pkg::*;

    localparam int SW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic               is_mc, accept, it_done;
    logic [2*WIDTH-1:0] it_acc;
    logic [WIDTH-1:0]   sum, diff, sc_result;
    logic               sc_ovf, sc_illegal;
    logic [WIDTH-1:0]   result_q, result_hi_q;
    logic               zero_q, ovf_q, illegal_q;

    assign is_mc  = is_multicycle(32'(bus.op));
    assign accept = (state_q == S_IDLE) && bus.in_valid;

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clock (clock),
        .reset (reset),
        .start (accept && is_mc),
`ifdef ALU_MC_DIV_EN
        .mode  (bus.op == OPW'(OP_DIV)),
`endif
        .a     (bus.A),
        .b     (bus.b),
        .done  (it_done),
        .acc   (it_acc)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = is_mc ? S_ITER : S_HOLD;
            end
            S_ITER: if (it_done) state_d = S_HOLD;
            S_HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle operations; anything unlisted here is treated as illegal.
    always_comb begin
        sum        = bus.A + bus.b;
        diff       = bus.A - bus.b;
        sc_result  = '0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        case (bus.op)
            OPW'(OP_ADD): begin
                sc_result = sum;
                sc_ovf    = (bus.A[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OPW'(OP_SUB): begin
                sc_result = diff;
                sc_ovf    = (bus.A[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OPW'(OP_SLT): sc_result = {{(WIDTH-1){1'b0}}, (bus.A < bus.b)};
            OPW'(OP_SLL): sc_result = (bus.b >= WIDTH'(WIDTH)) ? '0 : (bus.A << bus.b[SW-1:0]);
            OPW'(OP_SLR): sc_result = (bus.b >= WIDTH'(WIDTH)) ? '0 : (bus.A >> bus.b[SW-1:0]);
            OPW'(OP_AND): sc_result = bus.A & bus.b;
            default:      sc_illegal = 1'b1;
        endcase
    end

    // Result and flag registers, written once per operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept && !is_mc) begin
            result_q    <= sc_result;
            result_hi_q <= '0;
            zero_q      <= (sc_result == '0);
            ovf_q       <= sc_ovf;
            illegal_q   <= sc_illegal;
        end else if ((state_q == S_ITER) && it_done) begin
            result_q    <= it_acc[WIDTH-1:0];
            result_hi_q <= it_acc[2*WIDTH-1:WIDTH];
            zero_q      <= (it_acc[WIDTH-1:0] == '0);
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end
    end

    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=16 main instance, WIDTH=8 for the
// narrow multiply). Define ALU_MC_DIV_EN to exercise the optional divider.
module tb_alu_mc;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    alu_mc_if #(.WIDTH(16), .OPW(4)) bus16 ();
    alu_mc_if #(.WIDTH(8),  .OPW(4)) bus8 ();

    alu_mc #(.WIDTH(16), .OPW(4)) u_dut16 (.clock(clock), .reset(reset), .bus(bus16));
    alu_mc #(.WIDTH(8),  .OPW(4)) u_dut8  (.clock(clock), .reset(reset), .bus(bus8));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int     op;
        longint a, b;
        longint r, hi;
        bit     z, ov, il;
        int     lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int op, longint a, longint b, longint r, longint hi,
                                bit z, bit ov, bit il, int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.r = r; v.hi = hi;
        v.z = z; v.ov = ov; v.il = il; v.lat = lat;
        return v;
    endfunction

    function automatic longint sgn16(longint x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Reference: plain integer arithmetic on the 16-bit opcode definitions.
    function automatic vec_t model(int op, longint a, longint b);
        vec_t   v;
        longint s;
        longint m = 65536;
        v = mk(op, a, b, 0, 0, 0, 0, 0, 1);
        case (op)
            0: begin
                v.r  = (a + b) % m;
                s    = sgn16(a) + sgn16(b);
                v.ov = (s > 32767) || (s < -32768);
            end
            1: begin
                v.r  = (a - b + m) % m;
                s    = sgn16(a) - sgn16(b);
                v.ov = (s > 32767) || (s < -32768);
            end
            2: v.r = (a < b) ? 1 : 0;
            3: v.r = (b >= 16) ? 0 : ((a << b) % m);
            4: v.r = (b >= 16) ? 0 : (a >> b);
            5: v.r = a & b;
            6: begin
                v.r   = (a * b) % m;
                v.hi  = (a * b) / m;
                v.lat = 17;
            end
`ifdef ALU_MC_DIV_EN
            7: begin
                v.r   = (b == 0) ? 65535 : a / b;
                v.hi  = (b == 0) ? a : a % b;
                v.lat = 17;
            end
`endif
            default: v.il = 1;
        endcase
        v.z = (v.r == 0);
        return v;
    endfunction

    // Issue one operation on the 16-bit instance with out_ready held high.
    task automatic do_op16(input int op, input longint a, input longint b, output vec_t o,
                           output bit valid_after);
        int n;
        @(negedge clock);
        bus16.op        = 4'(op);
        bus16.A         = 16'(a);
        bus16.b         = 16'(b);
        bus16.in_valid  = 1'b1;
        bus16.out_ready = 1'b1;
        n = 0;
        while (!bus16.in_ready && n < 64) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1 bus16.in_valid = 1'b0;
        o = mk(op, a, b, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        while (!bus16.out_valid && o.lat < 64) begin
            @(negedge clock);
            o.lat++;
        end
        o.r  = bus16.result;
        o.hi = bus16.result_hi;
        o.z  = bus16.zero;
        o.ov = bus16.ovf;
        o.il = bus16.illegal;
        @(negedge clock);
        valid_after = bus16.out_valid;
    endtask

    task automatic compare(input string tag, input vec_t got, input vec_t exp, input bit valid_after);
        check({tag, ".result"},    got.r,   exp.r);
        check({tag, ".result_hi"}, got.hi,  exp.hi);
        check({tag, ".zero"},      got.z,   exp.z);
        check({tag, ".ovf"},       got.ov,  exp.ov);
        check({tag, ".illegal"},   got.il,  exp.il);
        check({tag, ".latency"},   got.lat, exp.lat);
        check({tag, ".valid_one_cycle"}, valid_after, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb_alu_mc timeout");
    end

    initial begin
        vec_t   got, exp;
        bit     va, seen;
        int     n, op, lat8;
        longint a, b;

        reset = 1'b1;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
        bus16.A = '0; bus16.b = '0; bus16.op = '0;
        bus8.in_valid = 1'b0;  bus8.out_ready = 1'b1;
        bus8.A = '0;  bus8.b = '0;  bus8.op = '0;
        repeat (2) @(negedge clock);

        check("reset.in_ready",  bus16.in_ready,  1);
        check("reset.out_valid", bus16.out_valid, 0);
        check("reset.result",    bus16.result,    0);
        check("reset.result_hi", bus16.result_hi, 0);
        check("reset.zero",      bus16.zero,      0);
        check("reset.ovf",       bus16.ovf,       0);
        check("reset.illegal",   bus16.illegal,   0);
        reset = 1'b0;

        //                op  A        b        result   hi       z  ov il lat
        vecs.push_back(mk(0, 'h7FFF,  'h0001,  'h8000,  0,       0, 1, 0, 1));
        vecs.push_back(mk(1, 5,       5,       0,       0,       1, 0, 0, 1));
        vecs.push_back(mk(2, 3,       7,       1,       0,       0, 0, 0, 1));
        vecs.push_back(mk(2, 7,       3,       0,       0,       1, 0, 0, 1));
        vecs.push_back(mk(3, 'h0001,  16,      0,       0,       1, 0, 0, 1));
        vecs.push_back(mk(3, 'h0003,  'hFFFF,  0,       0,       1, 0, 0, 1));
        vecs.push_back(mk(3, 'h0001,  15,      'h8000,  0,       0, 0, 0, 1));
        vecs.push_back(mk(4, 'h8000,  15,      'h0001,  0,       0, 0, 0, 1));
        vecs.push_back(mk(5, 'hF0F0,  'h3C3C,  'h3030,  0,       0, 0, 0, 1));
        vecs.push_back(mk(1, 'h8000,  'h0001,  'h7FFF,  0,       0, 1, 0, 1));
        vecs.push_back(mk(6, 'hFFFF,  'hFFFF,  'h0001,  'hFFFE,  0, 0, 0, 17));
        vecs.push_back(mk(9, 'h1234,  'h5678,  0,       0,       1, 0, 1, 1));
`ifdef ALU_MC_DIV_EN
        vecs.push_back(mk(7, 100,     7,       14,      2,       0, 0, 0, 17));
        vecs.push_back(mk(7, 'h1234,  0,       'hFFFF,  'h1234,  0, 0, 0, 17));
`else
        vecs.push_back(mk(7, 100,     7,       0,       0,       1, 0, 1, 1));
        vecs.push_back(mk(7, 'h1234,  0,       0,       0,       1, 0, 1, 1));
`endif

        foreach (vecs[i]) begin
            do_op16(vecs[i].op, vecs[i].a, vecs[i].b, got, va);
            compare($sformatf("vec%0d", i), got, vecs[i], va);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 120; i++) begin
            op = $urandom_range(0, 10);
            a  = $urandom_range(0, 65535);
            b  = (op == 3 || op == 4) ? $urandom_range(0, 20) : $urandom_range(0, 65535);
            if (op == 7 && $urandom_range(0, 5) == 0) b = 0;
            if ($urandom_range(0, 7) == 0) a = 'hFFFF;
            exp = model(op, a, b);
            do_op16(op, a, b, got, va);
            compare($sformatf("rnd%0d", i), got, exp, va);
        end

        // Backpressure: hold out_ready low, attempt an ignored request in HOLD.
        @(negedge clock);
        bus16.op = 4'd6; bus16.A = 16'h1234; bus16.b = 16'h0010;
        bus16.in_valid = 1'b1; bus16.out_ready = 1'b0;
        @(posedge clock);
        #1 bus16.in_valid = 1'b0;
        n = 0;
        while (!bus16.out_valid && n < 64) begin
            @(negedge clock);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                bus16.op = 4'd0; bus16.A = 16'h0001; bus16.b = 16'h0001;
                bus16.in_valid = 1'b1;
            end
            check($sformatf("bp%0d.out_valid", k), bus16.out_valid, 1);
            check($sformatf("bp%0d.in_ready", k),  bus16.in_ready,  0);
            check($sformatf("bp%0d.result", k),    bus16.result,    'h2340);
            check($sformatf("bp%0d.result_hi", k), bus16.result_hi, 'h0001);
            @(negedge clock);
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        @(negedge clock);
        check("bp.release_out_valid", bus16.out_valid, 0);
        check("bp.release_in_ready",  bus16.in_ready,  1);

        // Abort a multiply mid-iteration with reset.
        @(negedge clock);
        bus16.op = 4'd6; bus16.A = 16'hFFFF; bus16.b = 16'hFFFF;
        bus16.in_valid = 1'b1;
        @(posedge clock);
        #1 bus16.in_valid = 1'b0;
        repeat (5) @(negedge clock);
        check("abort.iter_in_ready",  bus16.in_ready,  0);
        check("abort.iter_out_valid", bus16.out_valid, 0);
        reset = 1'b1;
        #1;
        check("abort.out_valid", bus16.out_valid, 0);
        check("abort.in_ready",  bus16.in_ready,  1);
        check("abort.result",    bus16.result,    0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (bus16.out_valid) seen = 1'b1;
        end
        check("abort.no_partial_result", seen, 0);
        do_op16(0, 2, 3, got, va);
        compare("abort.next_add", got, mk(0, 2, 3, 5, 0, 0, 0, 0, 1), va);

        // WIDTH=8 multiply.
        @(negedge clock);
        bus8.op = 4'd6; bus8.A = 8'hFF; bus8.b = 8'hFF;
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        @(posedge clock);
        #1 bus8.in_valid = 1'b0;
        lat8 = 1;
        @(negedge clock);
        while (!bus8.out_valid && lat8 < 64) begin
            @(negedge clock);
            lat8++;
        end
        check("w8mul.result",    bus8.result,    'h01);
        check("w8mul.result_hi", bus8.result_hi, 'hFE);
        check("w8mul.latency",   lat8,           9);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
